// File: rtl/ci_vector_driver.sv
// ci_vector_driver
//   Synthesizable stimulus source for CI benches. It plays a fixed,
//   parameter-packed sequence of WIDTH-bit vectors into a DUT over a
//   valid/ready handshake. It also publishes the index of the vector on
//   offer so that a checker can line up DUT outputs against the same step.
//
//   Optional build macro: CI_VECTOR_DRIVER_LOOP_EN
//     undefined : single pass. done stays high until the next start or reset.
//     defined   : the sequence repeats with no gap after the last vector.
//                 done pulses for one cycle per completed pass.
//
// Ports
//   clock      in   1      system clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      run request, sampled only in IDLE or DONE
//   out_data   out  WIDTH  current vector
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      sink accepts out_data this cycle
//   step       out  32     index of the vector on offer / last completed
//   busy       out  1      high while waiting or driving
//   done       out  1      high once the last vector has been accepted
module ci_vector_driver #(
    parameter int                     WIDTH       = 8,
    parameter int                     DEPTH       = 4,
    parameter int                     START_DELAY = 16,
    parameter logic [WIDTH*DEPTH-1:0] VECTORS     = {8'd4, 8'd3, 8'd2, 8'd1}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      step,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] step_q, step_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_end;
    logic [IDX_W-1:0] step_nxt;

    // Unpack the vector table; index 0 lives in the LSBs of VECTORS.
    logic [WIDTH-1:0] vec_mem [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
        assign vec_mem[gi] = VECTORS[gi*WIDTH +: WIDTH];
    end

    assign step_nxt = step_q + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        data_d   = data_q;
        valid_d  = valid_q;
        pass_end = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d = '0;
                    if (START_DELAY == 0) begin
                        // No settle time requested: offer vector 0 right away.
                        state_d = ST_DRIVE;
                        valid_d = 1'b1;
                        data_d  = vec_mem[0];
                        step_d  = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRIVE;
                    valid_d = 1'b1;
                    data_d  = vec_mem[0];
                    step_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DRIVE: begin
                // Without a transfer everything holds, keeping data/step stable.
                if (valid_q && out_ready) begin
                    if (step_q == LAST_IDX) begin
                        pass_end = 1'b1;
`ifdef CI_VECTOR_DRIVER_LOOP_EN
                        step_d  = '0;
                        data_d  = vec_mem[0];
`else
                        state_d = ST_DONE;
                        valid_d = 1'b0;
`endif
                    end else begin
                        step_d = step_nxt;
                        data_d = vec_mem[step_nxt];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_DRIVE);
`ifdef CI_VECTOR_DRIVER_LOOP_EN
        done_d = pass_end;
`else
        done_d = (state_d == ST_DONE);
`endif
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign step      = {{(32-IDX_W){1'b0}}, step_q};
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ci_vector_driver.sv
module tb_ci_vector_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        ready0 = 1'b1, ready1 = 1'b1;
    logic [7:0]  data0, data1;
    logic        valid0, valid1, busy0, busy1, done0, done1;
    logic [31:0] step0, step1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Default configuration: 4 vectors {1,2,3,4}, 16 cycles of start delay.
    ci_vector_driver dut0 (
        .clock(clock), .reset(reset), .start(start0),
        .out_data(data0), .out_valid(valid0), .out_ready(ready0),
        .step(step0), .busy(busy0), .done(done0)
    );

    // Corner configuration: a single vector (3) and no start delay.
    ci_vector_driver #(.WIDTH(8), .DEPTH(1), .START_DELAY(0), .VECTORS(8'd3)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .out_data(data1), .out_valid(valid1), .out_ready(ready1),
        .step(step1), .busy(busy1), .done(done1)
    );

    // Reference model: phase 0 idle, 1 waiting, 2 driving, 3 finished.
    // The wait phase counts down the number of remaining delay cycles.
    int m_phase [2];
    int m_left  [2];
    int m_idx   [2];
    int m_data  [2];
    int depth_of [2] = '{4, 1};
    int delay_of [2] = '{16, 0};

    function automatic int vec_val(input int k, input int i);
        return (k == 0) ? i + 1 : 3;
    endfunction

    task automatic model_step(input int k, input bit st, input bit rdy, input bit rst);
        if (rst) begin
            m_phase[k] = 0; m_left[k] = 0; m_idx[k] = 0; m_data[k] = 0;
        end else begin
            case (m_phase[k])
                0, 3: if (st) begin
                    if (delay_of[k] == 0) begin
                        m_phase[k] = 2; m_idx[k] = 0; m_data[k] = vec_val(k, 0);
                    end else begin
                        m_phase[k] = 1; m_left[k] = delay_of[k];
                    end
                end
                1: begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_phase[k] = 2; m_idx[k] = 0; m_data[k] = vec_val(k, 0);
                    end
                end
                2: if (rdy) begin
                    if (m_idx[k] == depth_of[k] - 1) m_phase[k] = 3;
                    else begin
                        m_idx[k]  = m_idx[k] + 1;
                        m_data[k] = vec_val(k, m_idx[k]);
                    end
                end
                default: m_phase[k] = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        chk("d0_valid", 32'(valid0), 32'(m_phase[0] == 2));
        chk("d0_data",  32'(data0),  32'(m_data[0]));
        chk("d0_step",  step0,       32'(m_idx[0]));
        chk("d0_busy",  32'(busy0),  32'(m_phase[0] == 1 || m_phase[0] == 2));
        chk("d0_done",  32'(done0),  32'(m_phase[0] == 3));
        chk("d1_valid", 32'(valid1), 32'(m_phase[1] == 2));
        chk("d1_data",  32'(data1),  32'(m_data[1]));
        chk("d1_step",  step1,       32'(m_idx[1]));
        chk("d1_busy",  32'(busy1),  32'(m_phase[1] == 1 || m_phase[1] == 2));
        chk("d1_done",  32'(done1),  32'(m_phase[1] == 3));
    endtask

    // One clock: model follows the inputs seen at the edge, outputs are
    // compared 1 time unit later.
    task automatic tick();
        @(posedge clock);
        model_step(0, start0, ready0, reset);
        model_step(1, start1, ready1, reset);
        #1;
        compare_all();
    endtask

    task automatic wait_step0(input int s);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (valid0 && step0 == 32'(s)) ok = 1'b1;
            else tick();
        end
        chk("wait_step", 32'(ok), 32'd1);
    endtask

    initial begin
        int lat0, lat1;

        // Reset
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // First run, both instances started together, ready held high
        start0 = 1'b1; start1 = 1'b1;
        lat0 = 0; lat1 = 0;
        for (int i = 1; i <= 40 && (lat0 == 0 || lat1 == 0); i++) begin
            tick();
            start0 = 1'b0; start1 = 1'b0;
            if (valid0 && lat0 == 0) lat0 = i;
            if (valid1 && lat1 == 0) lat1 = i;
        end
        chk("latency_default", 32'(lat0), 32'd17);
        chk("latency_depth1",  32'(lat1), 32'd1);
        repeat (6) tick();
        chk("done_after_run", 32'(done0), 32'd1);
        chk("step_after_run", step0, 32'd3);

        // Restart from DONE; start pulses in WAIT and DRIVE must be ignored
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("restart_busy", 32'(busy0), 32'd1);
        chk("restart_done", 32'(done0), 32'd0);
        repeat (3) tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        wait_step0(1);

        // Back-pressure at step 1
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start0 = 1'b1;
            tick();
            start0 = 1'b0;
            chk("bp_hold_data", 32'(data0), 32'd2);
            chk("bp_hold_step", step0, 32'd1);
        end
        ready0 = 1'b1;
        tick();
        chk("bp_adv_data", 32'(data0), 32'd3);
        chk("bp_adv_step", step0, 32'd2);
        repeat (4) tick();

        // Reset during DRIVE at step 2, then replay
        start0 = 1'b1; tick(); start0 = 1'b0;
        wait_step0(2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_step",  step0, 32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_done",  32'(done0), 32'd0);
        start0 = 1'b1; tick(); start0 = 1'b0;
        wait_step0(0);
        chk("replay_first", 32'(data0), 32'd1);
        repeat (6) tick();

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 600; i++) begin
            ready0 = ($urandom_range(3) != 0);
            ready1 = ($urandom_range(2) != 0);
            start0 = ($urandom_range(15) == 0);
            start1 = ($urandom_range(7) == 0);
            reset  = ($urandom_range(199) == 0);
            tick();
        end
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
